// File: rtl/myproject_udiv_17ns_8ns_10_seq.sv
// rtl/myproject_udiv_17ns_8ns_10_seq.sv - sequential restoring divider, 17b/8b -> 10b saturating quotient
// Optional remainder output under MYPROJECT_UDIV_REM_EN.
module myproject_udiv_17ns_8ns_10_seq #(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 17,
  parameter int din0_WIDTH = 17,
  parameter int din1_WIDTH = 8,
  parameter int dout_WIDTH = 10
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ce,
  input  logic                  start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic [dout_WIDTH-1:0] dout,
`ifdef MYPROJECT_UDIV_REM_EN
  output logic [din1_WIDTH-1:0] rem,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic                  dbz
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int CNT_W = $clog2(NUM_STAGE + 1);

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [din0_WIDTH-1:0] quo_q, quo_d;
  logic [din1_WIDTH-1:0] prem_q, prem_d;
  logic [din1_WIDTH-1:0] divisor_q, divisor_d;
  logic                  zero_q, zero_d;
  logic [dout_WIDTH-1:0] dout_q, dout_d;
  logic                  ovf_q, ovf_d;
  logic                  dbz_q, dbz_d;
`ifdef MYPROJECT_UDIV_REM_EN
  logic [din1_WIDTH-1:0] rem_q, rem_d;
`endif

  logic                  accept;
  logic [din1_WIDTH:0]   trial;
  logic                  fits;
  logic [din1_WIDTH:0]   trial_sub;
  logic [din1_WIDTH-1:0] prem_step;
  logic [din0_WIDTH-1:0] quo_step;
  logic                  quo_big;
  logic                  unused_id;

  assign unused_id = ^ID;

  // quo_q starts as the dividend and shifts left; its MSB feeds the partial remainder
  // while the new quotient bit enters at the LSB.
  assign trial     = {prem_q, quo_q[din0_WIDTH-1]};
  assign fits      = trial >= {1'b0, divisor_q};
  assign trial_sub = trial - {1'b0, divisor_q};
  assign prem_step = fits ? trial_sub[din1_WIDTH-1:0] : trial[din1_WIDTH-1:0];
  assign quo_step  = {quo_q[din0_WIDTH-2:0], fits};
  assign quo_big   = |quo_step[din0_WIDTH-1:dout_WIDTH];

  // A zero divisor parks in IDLE for one cycle (zero_q) so DONE lands a cycle later
  // without ever passing through RUN.
  assign accept = ce && start && (((state_q == S_IDLE) && !zero_q) || (state_q == S_DONE));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    prem_d    = prem_q;
    divisor_d = divisor_q;
    zero_d    = zero_q;
    dout_d    = dout_q;
    ovf_d     = ovf_q;
    dbz_d     = dbz_q;
`ifdef MYPROJECT_UDIV_REM_EN
    rem_d     = rem_q;
`endif
    if (ce) begin
      case (state_q)
        S_IDLE: begin
          if (zero_q) begin
            state_d = S_DONE;
            zero_d  = 1'b0;
            dout_d  = '1;
            ovf_d   = 1'b0;
            dbz_d   = 1'b1;
`ifdef MYPROJECT_UDIV_REM_EN
            rem_d   = '0;
`endif
          end
        end
        S_RUN: begin
          quo_d  = quo_step;
          prem_d = prem_step;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(NUM_STAGE - 1)) begin
            state_d = S_DONE;
            cnt_d   = '0;
            dout_d  = quo_big ? '1 : quo_step[dout_WIDTH-1:0];
            ovf_d   = quo_big;
            dbz_d   = 1'b0;
`ifdef MYPROJECT_UDIV_REM_EN
            rem_d   = prem_step;
`endif
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
      if (accept) begin
        ovf_d     = 1'b0;
        dbz_d     = 1'b0;
        divisor_d = din1;
        quo_d     = din0;
        prem_d    = '0;
        cnt_d     = '0;
        if (din1 == '0) begin
          state_d = S_IDLE;
          zero_d  = 1'b1;
        end else begin
          state_d = S_RUN;
          zero_d  = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      quo_q     <= '0;
      prem_q    <= '0;
      divisor_q <= '0;
      zero_q    <= 1'b0;
      dout_q    <= '0;
      ovf_q     <= 1'b0;
      dbz_q     <= 1'b0;
`ifdef MYPROJECT_UDIV_REM_EN
      rem_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      prem_q    <= prem_d;
      divisor_q <= divisor_d;
      zero_q    <= zero_d;
      dout_q    <= dout_d;
      ovf_q     <= ovf_d;
      dbz_q     <= dbz_d;
`ifdef MYPROJECT_UDIV_REM_EN
      rem_q     <= rem_d;
`endif
    end
  end

  assign dout = dout_q;
  assign ovf  = ovf_q;
  assign dbz  = dbz_q;
  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
`ifdef MYPROJECT_UDIV_REM_EN
  assign rem  = rem_q;
`endif

endmodule

// File: tb/tb_myproject_udiv_17ns_8ns_10_seq.sv
// tb/tb_myproject_udiv_17ns_8ns_10_seq.sv - scoreboard bench for the sequential divider
// Remainder checks are active when MYPROJECT_UDIV_REM_EN is defined.
module tb_myproject_udiv_17ns_8ns_10_seq;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        ce;
  logic        start;
  logic [16:0] din0;
  logic [7:0]  din1;
  logic [9:0]  dout;
  logic        busy, done, ovf, dbz;
`ifdef MYPROJECT_UDIV_REM_EN
  logic [7:0]  rem;
`endif

  myproject_udiv_17ns_8ns_10_seq dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .ce       (ce),
    .start    (start),
    .din0     (din0),
    .din1     (din1),
    .dout     (dout),
`ifdef MYPROJECT_UDIV_REM_EN
    .rem      (rem),
`endif
    .busy     (busy),
    .done     (done),
    .ovf      (ovf),
    .dbz      (dbz)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic [9:0] dout;
    logic [7:0] rem;
    logic       ovf;
    logic       dbz;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic push_exp(input logic [16:0] d0, input logic [7:0] d1, input int stall_len);
    exp_t e;
    int   q;
    if (d1 == 0) begin
      e.dout = 10'h3ff; e.rem = 8'd0; e.ovf = 1'b0; e.dbz = 1'b1; e.lat = 2;
    end else begin
      q = int'(d0) / int'(d1);
      e.ovf  = (q > 1023);
      e.dout = e.ovf ? 10'h3ff : q[9:0];
      e.rem  = 8'(int'(d0) % int'(d1));
      e.dbz  = 1'b0;
      e.lat  = 18 + stall_len;
    end
    sb.push_back(e);
  endtask

  // Starts one operation and waits for done; lat counts edges from the accept edge to done.
  task automatic run_op(input logic [16:0] d0, input logic [7:0] d1, input int stall_at,
                        input int stall_len, input int extra_at,
                        output int lat, output bit saw_busy, output bit flags_clr);
    int n;
    @(negedge ap_clk);
    din0 = d0; din1 = d1; start = 1'b1; ce = 1'b1;
    @(posedge ap_clk);
    #1;
    start = 1'b0;
    n = 1;
    saw_busy = busy;
    flags_clr = (ovf == 1'b0) && (dbz == 1'b0);
    lat = -1;
    while (n < 300) begin
      ce = !(n >= stall_at && n < stall_at + stall_len);
      start = (n == extra_at);
      if (n == extra_at) begin
        din0 = 17'd99999; din1 = 8'd3;
      end
      @(posedge ap_clk);
      #1;
      n++;
      start = 1'b0;
      ce = 1'b1;
      if (busy) saw_busy = 1'b1;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset;
    ap_rst_n = 1'b0; ce = 1'b0; start = 1'b0; din0 = '0; din1 = '0;
    repeat (3) @(posedge ap_clk);
    #1;
    n_total++;
    if ({dout, busy, done, ovf, dbz} !== 14'd0) $display("FAIL reset_outputs got %h want 0", {dout, busy, done, ovf, dbz});
    else n_pass++;
`ifdef MYPROJECT_UDIV_REM_EN
    n_total++;
    if (rem !== 8'd0) $display("FAIL reset_rem got %0d want 0", rem);
    else n_pass++;
`endif
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
  endtask

  task automatic test_vectors;
    logic [16:0] d0s[6] = '{17'd130944, 17'd12345, 17'd100000, 17'd131071, 17'd0, 17'd255};
    logic [7:0]  d1s[6] = '{8'd128, 8'd100, 8'd7, 8'd255, 8'd5, 8'd1};
    int lat; bit sb_busy, clr; exp_t e;
    for (int i = 0; i < 10; i++) begin
      logic [16:0] a; logic [7:0] b;
      if (i < 6) begin a = d0s[i]; b = d1s[i]; end
      else begin a = 17'($urandom_range(0, 131071)); b = 8'($urandom_range(1, 255)); end
      push_exp(a, b, 0);
      run_op(a, b, 1000, 0, -1, lat, sb_busy, clr);
      e = sb.pop_front();
      n_total++;
      if (lat !== e.lat) $display("FAIL vec%0d_latency got %0d want %0d", i, lat, e.lat);
      else n_pass++;
      n_total++;
      if ({dout, ovf, dbz} !== {e.dout, e.ovf, e.dbz})
        $display("FAIL vec%0d_result %0d/%0d got dout=%0d ovf=%b dbz=%b want dout=%0d ovf=%b dbz=%b",
                 i, a, b, dout, ovf, dbz, e.dout, e.ovf, e.dbz);
      else n_pass++;
`ifdef MYPROJECT_UDIV_REM_EN
      n_total++;
      if (rem !== e.rem) $display("FAIL vec%0d_rem got %0d want %0d", i, rem, e.rem);
      else n_pass++;
`endif
      if (i == 0) begin
        @(posedge ap_clk);
        #1;
        n_total++;
        if (done !== 1'b0) $display("FAIL done_single_pulse got %b want 0", done);
        else n_pass++;
      end
    end
  endtask

  task automatic test_div_by_zero;
    int lat; bit sb_busy, clr; exp_t e;
    push_exp(17'd500, 8'd0, 0);
    run_op(17'd500, 8'd0, 1000, 0, -1, lat, sb_busy, clr);
    e = sb.pop_front();
    n_total++;
    if (lat !== e.lat) $display("FAIL dbz_latency got %0d want %0d", lat, e.lat);
    else n_pass++;
    n_total++;
    if ({dout, ovf, dbz, sb_busy} !== {e.dout, e.ovf, e.dbz, 1'b0})
      $display("FAIL dbz_result got dout=%0d ovf=%b dbz=%b busy_seen=%b want 1023/0/1/0", dout, ovf, dbz, sb_busy);
    else n_pass++;
`ifdef MYPROJECT_UDIV_REM_EN
    n_total++;
    if (rem !== e.rem) $display("FAIL dbz_rem got %0d want %0d", rem, e.rem);
    else n_pass++;
`endif
  endtask

  task automatic test_back_to_back;
    int lat; bit sb_busy, clr; exp_t e;
    // Started while still in DONE from the previous op; dbz must clear on accept.
    push_exp(17'd100000, 8'd7, 0);
    run_op(17'd100000, 8'd7, 1000, 0, -1, lat, sb_busy, clr);
    e = sb.pop_front();
    n_total++;
    if (!clr) $display("FAIL b2b_flags_clear_on_accept got set want clear");
    else n_pass++;
    n_total++;
    if ({lat, dout, ovf, sb_busy} !== {e.lat, e.dout, e.ovf, 1'b1})
      $display("FAIL b2b_ovf got lat=%0d dout=%0d ovf=%b want lat=%0d dout=%0d ovf=%b", lat, dout, ovf, e.lat, e.dout, e.ovf);
    else n_pass++;
    push_exp(17'd12345, 8'd100, 0);
    run_op(17'd12345, 8'd100, 1000, 0, -1, lat, sb_busy, clr);
    e = sb.pop_front();
    n_total++;
    if (!clr) $display("FAIL b2b_ovf_clear_on_accept got set want clear");
    else n_pass++;
    n_total++;
    if ({lat, dout, ovf, dbz} !== {e.lat, e.dout, e.ovf, e.dbz})
      $display("FAIL b2b_second got lat=%0d dout=%0d want lat=%0d dout=%0d", lat, dout, e.lat, e.dout);
    else n_pass++;
  endtask

  task automatic test_ce_stall;
    int lat; bit sb_busy, clr; exp_t e;
    push_exp(17'd12345, 8'd100, 5);
    run_op(17'd12345, 8'd100, 6, 5, 3, lat, sb_busy, clr);
    e = sb.pop_front();
    n_total++;
    if (lat !== e.lat) $display("FAIL stall_latency got %0d want %0d", lat, e.lat);
    else n_pass++;
    n_total++;
    if ({dout, ovf, dbz} !== {e.dout, e.ovf, e.dbz})
      $display("FAIL stall_result got dout=%0d ovf=%b want dout=%0d ovf=%b", dout, ovf, e.dout, e.ovf);
    else n_pass++;
`ifdef MYPROJECT_UDIV_REM_EN
    n_total++;
    if (rem !== e.rem) $display("FAIL stall_rem got %0d want %0d", rem, e.rem);
    else n_pass++;
`endif
  endtask

  task automatic test_reset_mid_run;
    int lat; bit sb_busy, clr; exp_t e; bit saw_done;
    @(negedge ap_clk);
    din0 = 17'd12345; din1 = 8'd100; start = 1'b1; ce = 1'b1;
    @(posedge ap_clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b0;
    #1;
    n_total++;
    if ({dout, busy, done, ovf, dbz} !== 14'd0) $display("FAIL midrun_reset_outputs got %h want 0", {dout, busy, done, ovf, dbz});
    else n_pass++;
`ifdef MYPROJECT_UDIV_REM_EN
    n_total++;
    if (rem !== 8'd0) $display("FAIL midrun_reset_rem got %0d want 0", rem);
    else n_pass++;
`endif
    saw_done = 1'b0;
    repeat (3) begin
      @(posedge ap_clk);
      #1;
      if (done) saw_done = 1'b1;
    end
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    repeat (20) begin
      @(posedge ap_clk);
      #1;
      if (done) saw_done = 1'b1;
    end
    n_total++;
    if (saw_done) $display("FAIL midrun_reset_no_done got done want none");
    else n_pass++;
    push_exp(17'd50000, 8'd250, 0);
    run_op(17'd50000, 8'd250, 1000, 0, -1, lat, sb_busy, clr);
    e = sb.pop_front();
    n_total++;
    if ({lat, dout, ovf, dbz} !== {e.lat, e.dout, e.ovf, e.dbz})
      $display("FAIL post_reset_op got lat=%0d dout=%0d want lat=%0d dout=%0d", lat, dout, e.lat, e.dout);
    else n_pass++;
`ifdef MYPROJECT_UDIV_REM_EN
    n_total++;
    if (rem !== e.rem) $display("FAIL post_reset_rem got %0d want %0d", rem, e.rem);
    else n_pass++;
`endif
  endtask

  task automatic test_start_after_reset;
    int lat; bit sb_busy, clr; exp_t e;
    ap_rst_n = 1'b0;
    @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    push_exp(17'd1000, 8'd10, 0);
    run_op(17'd1000, 8'd10, 1000, 0, -1, lat, sb_busy, clr);
    e = sb.pop_front();
    n_total++;
    if ({lat, dout} !== {e.lat, e.dout})
      $display("FAIL first_edge_accept got lat=%0d dout=%0d want lat=%0d dout=%0d", lat, dout, e.lat, e.dout);
    else n_pass++;
  endtask

  initial begin
    test_reset;
    test_vectors;
    test_div_by_zero;
    test_back_to_back;
    test_ce_stall;
    test_reset_mid_run;
    test_start_after_reset;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
